// File: rtl/roi_pkg.sv
// roi_pkg: shared types and constants for the ROI statistics controller.
//   - default frame geometry and ROI size/step
//   - rgb444_t: packed RGB444 pixel {r, g, b}
//   - roi_state_e: controller FSM states
//   - roi_centre(): centred start position of the window along one axis
package roi_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int ROI_LOG2_DEF = 4;
    localparam int STEP_DEF     = 8;

    // Coordinate widths are fixed by the capture timing counters.
    localparam int X_W = 10;
    localparam int Y_W = 9;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        ACCUM      = 2'd1,
        DONE       = 2'd2
    } roi_state_e;

    function automatic int roi_centre(input int active, input int roi_log2);
        return (active - (1 << roi_log2)) / 2;
    endfunction

    localparam logic [X_W-1:0] ROI_X_RST = X_W'(roi_centre(H_ACTIVE_DEF, ROI_LOG2_DEF));
    localparam logic [Y_W-1:0] ROI_Y_RST = Y_W'(roi_centre(V_ACTIVE_DEF, ROI_LOG2_DEF));

endpackage

// File: rtl/roi_stats_ctrl_if.sv
// roi_stats_ctrl_if: bundle between capture timing / overlay logic and the ROI
// statistics controller.
//   master : camera timing + user steps (drives video/step), consumes ROI/stats
//   slave  : the controller
// Signalling: there is no backpressure anywhere. frame_start, step_* and
// stats_valid are single-cycle pulses that are acted on in the cycle they are
// high; pix_valid qualifies x_count/y_count/video_in in the same cycle.
// dbg_state exposes the controller FSM state for observation.
interface roi_stats_ctrl_if;
    import roi_pkg::*;

    logic                 frame_start;
    logic                 pix_valid;
    logic [X_W-1:0]       x_count;
    logic [Y_W-1:0]       y_count;
    rgb444_t              video_in;
    logic                 step_up;
    logic                 step_down;
    logic                 step_left;
    logic                 step_right;
    logic [X_W-1:0]       roi_x_min;
    logic [X_W-1:0]       roi_x_max;
    logic [Y_W-1:0]       roi_y_min;
    logic [Y_W-1:0]       roi_y_max;
    rgb444_t              avg_rgb;
    logic                 stats_valid;
    logic                 busy;
    roi_state_e           dbg_state;

    modport master (
        output frame_start, pix_valid, x_count, y_count, video_in,
               step_up, step_down, step_left, step_right,
        input  roi_x_min, roi_x_max, roi_y_min, roi_y_max,
               avg_rgb, stats_valid, busy, dbg_state
    );

    modport slave (
        input  frame_start, pix_valid, x_count, y_count, video_in,
               step_up, step_down, step_left, step_right,
        output roi_x_min, roi_x_max, roi_y_min, roi_y_max,
               avg_rgb, stats_valid, busy, dbg_state
    );

endinterface

// File: rtl/roi_pos_reg.sv
// roi_pos_reg: pending ROI position moved by step pulses, copied to the active
// (published) window on frame_start.
//   clk, resetn               : clock, async active-low reset
//   i_frame_start             : latch pending position into the active window
//   i_step_up/down/left/right : one-cycle move requests of STEP pixels
//   o_x_min/o_x_max           : active window columns (inclusive)
//   o_y_min/o_y_max           : active window rows (inclusive)
module roi_pos_reg
    import roi_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int ROI_LOG2 = ROI_LOG2_DEF,
    parameter int STEP     = STEP_DEF
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           i_frame_start,
    input  logic           i_step_up,
    input  logic           i_step_down,
    input  logic           i_step_left,
    input  logic           i_step_right,
    output logic [X_W-1:0] o_x_min,
    output logic [X_W-1:0] o_x_max,
    output logic [Y_W-1:0] o_y_min,
    output logic [Y_W-1:0] o_y_max
);

    localparam int             W      = 1 << ROI_LOG2;
    localparam logic [X_W-1:0] X_LIM  = X_W'(H_ACTIVE - W);
    localparam logic [Y_W-1:0] Y_LIM  = Y_W'(V_ACTIVE - W);
    localparam logic [X_W-1:0] X_STEP = X_W'(STEP);
    localparam logic [Y_W-1:0] Y_STEP = Y_W'(STEP);
    localparam logic [X_W-1:0] X_SPAN = X_W'(W - 1);
    localparam logic [Y_W-1:0] Y_SPAN = Y_W'(W - 1);
    localparam logic [X_W-1:0] X_RST  = X_W'(roi_centre(H_ACTIVE, ROI_LOG2));
    localparam logic [Y_W-1:0] Y_RST  = Y_W'(roi_centre(V_ACTIVE, ROI_LOG2));

    logic [X_W-1:0] r_px;
    logic [Y_W-1:0] r_py;
    logic [X_W-1:0] w_px_next;
    logic [Y_W-1:0] w_py_next;
    logic [X_W-1:0] r_x_min;
    logic [X_W-1:0] r_x_max;
    logic [Y_W-1:0] r_y_min;
    logic [Y_W-1:0] r_y_max;

    // Opposite requests cancel; a move that would overshoot saturates at the
    // bound. Comparing before the add/sub keeps the arithmetic in range.
    always_comb begin
        w_px_next = r_px;
        w_py_next = r_py;
        if (i_step_left && !i_step_right) begin
            w_px_next = (r_px < X_STEP) ? '0 : r_px - X_STEP;
        end else if (i_step_right && !i_step_left) begin
            w_px_next = (r_px > X_LIM - X_STEP) ? X_LIM : r_px + X_STEP;
        end
        if (i_step_up && !i_step_down) begin
            w_py_next = (r_py < Y_STEP) ? '0 : r_py - Y_STEP;
        end else if (i_step_down && !i_step_up) begin
            w_py_next = (r_py > Y_LIM - Y_STEP) ? Y_LIM : r_py + Y_STEP;
        end
    end

    // The active window samples the pre-step pending value, so a step arriving
    // together with frame_start only takes effect from the following frame.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_px    <= X_RST;
            r_py    <= Y_RST;
            r_x_min <= X_RST;
            r_x_max <= X_RST + X_SPAN;
            r_y_min <= Y_RST;
            r_y_max <= Y_RST + Y_SPAN;
        end else begin
            r_px <= w_px_next;
            r_py <= w_py_next;
            if (i_frame_start) begin
                r_x_min <= r_px;
                r_x_max <= r_px + X_SPAN;
                r_y_min <= r_py;
                r_y_max <= r_py + Y_SPAN;
            end
        end
    end

    assign o_x_min = r_x_min;
    assign o_x_max = r_x_max;
    assign o_y_min = r_y_min;
    assign o_y_max = r_y_max;

endmodule

// File: rtl/roi_stats_ctrl.sv
// roi_stats_ctrl: frame-synchronous ROI controller. Publishes the ROI window on
// frame_start and reports the mean RGB444 colour of the window per frame.
//   clk, resetn : pixel clock, async active-low reset
//   bus (slave) : video timing/pixels and step pulses in; active window,
//                 avg_rgb, stats_valid pulse, busy and FSM state out
module roi_stats_ctrl
    import roi_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int ROI_LOG2 = ROI_LOG2_DEF,
    parameter int STEP     = STEP_DEF
) (
    input logic             clk,
    input logic             resetn,
    roi_stats_ctrl_if.slave bus
);

    localparam int          AW   = 4 + 2 * ROI_LOG2;  // per-channel sum width
    localparam int          CW   = 2 * ROI_LOG2 + 1;  // pixel count width
    localparam logic [CW-1:0] FULL = CW'(1 << (2 * ROI_LOG2));

    logic [X_W-1:0] w_x_min;
    logic [X_W-1:0] w_x_max;
    logic [Y_W-1:0] w_y_min;
    logic [Y_W-1:0] w_y_max;
    logic           w_in_win;
    logic           w_at_last;
    logic [CW-1:0]  w_cnt_inc;

    roi_state_e     r_state;
    logic [AW-1:0]  r_acc_r;
    logic [AW-1:0]  r_acc_g;
    logic [AW-1:0]  r_acc_b;
    logic [CW-1:0]  r_cnt;
    rgb444_t        r_avg;
    logic           r_stats_valid;
    logic           r_busy;

    roi_pos_reg #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .ROI_LOG2 (ROI_LOG2),
        .STEP     (STEP)
    ) u_pos (
        .clk           (clk),
        .resetn        (resetn),
        .i_frame_start (bus.frame_start),
        .i_step_up     (bus.step_up),
        .i_step_down   (bus.step_down),
        .i_step_left   (bus.step_left),
        .i_step_right  (bus.step_right),
        .o_x_min       (w_x_min),
        .o_x_max       (w_x_max),
        .o_y_min       (w_y_min),
        .o_y_max       (w_y_max)
    );

    assign w_in_win  = bus.pix_valid
                    && (bus.x_count >= w_x_min) && (bus.x_count <= w_x_max)
                    && (bus.y_count >= w_y_min) && (bus.y_count <= w_y_max);
    assign w_at_last = (bus.x_count == w_x_max) && (bus.y_count == w_y_max);
    assign w_cnt_inc = r_cnt + 1'b1;

    // frame_start always wins: in ACCUM it abandons the partial frame, and in
    // DONE the result is still published while the new frame starts at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= WAIT_FRAME;
            r_acc_r       <= '0;
            r_acc_g       <= '0;
            r_acc_b       <= '0;
            r_cnt         <= '0;
            r_avg         <= '0;
            r_stats_valid <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_stats_valid <= 1'b0;
            case (r_state)
                WAIT_FRAME: begin
                    if (bus.frame_start) begin
                        r_state <= ACCUM;
                        r_busy  <= 1'b1;
                        r_acc_r <= '0;
                        r_acc_g <= '0;
                        r_acc_b <= '0;
                        r_cnt   <= '0;
                    end
                end
                ACCUM: begin
                    if (bus.frame_start) begin
                        r_acc_r <= '0;
                        r_acc_g <= '0;
                        r_acc_b <= '0;
                        r_cnt   <= '0;
                    end else if (w_in_win) begin
                        r_acc_r <= r_acc_r + AW'(bus.video_in.r);
                        r_acc_g <= r_acc_g + AW'(bus.video_in.g);
                        r_acc_b <= r_acc_b + AW'(bus.video_in.b);
                        r_cnt   <= w_cnt_inc;
                        // Bottom-right pixel closes the window; a short count
                        // means pixels were missed, so the frame is dropped.
                        if (w_at_last) begin
                            r_busy  <= 1'b0;
                            r_state <= (w_cnt_inc == FULL) ? DONE : WAIT_FRAME;
                        end
                    end
                end
                DONE: begin
                    // Window is 2**ROI_LOG2 square, so the mean is the top
                    // four bits of each sum.
                    r_avg.r       <= r_acc_r[AW-1 -: 4];
                    r_avg.g       <= r_acc_g[AW-1 -: 4];
                    r_avg.b       <= r_acc_b[AW-1 -: 4];
                    r_stats_valid <= 1'b1;
                    if (bus.frame_start) begin
                        r_state <= ACCUM;
                        r_busy  <= 1'b1;
                        r_acc_r <= '0;
                        r_acc_g <= '0;
                        r_acc_b <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= WAIT_FRAME;
                    end
                end
                default: begin
                    r_state <= WAIT_FRAME;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.roi_x_min   = w_x_min;
    assign bus.roi_x_max   = w_x_max;
    assign bus.roi_y_min   = w_y_min;
    assign bus.roi_y_max   = w_y_max;
    assign bus.avg_rgb     = r_avg;
    assign bus.stats_valid = r_stats_valid;
    assign bus.busy        = r_busy;
    assign bus.dbg_state   = r_state;

endmodule
